rv32i_apb_bridge: RTL and testbench

- Parametrised successor to the fixed single-cycle data-RAM path.
- Converts the RV32I core's data-memory request (dAddr/dWdata/d_wr_en/extend_controls) into APB3 transfers to NUM_SLAVES peripherals.
- Adds wait-state support: a d_ready stall handshake, byte strobes, load extension and an error response.
- Sits between RV32I_Core and the peripheral slots of a multi-peripheral RV32I top.

---
 rtl/rv32i_apb_bridge.sv | 178 +++++++++++++++++
 tb/tb_rv32i_apb_bridge.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_apb_bridge.sv
// rtl/rv32i_apb_bridge.sv - RV32I data port to APB3 bridge with wait states, strobes, load extension and errors
// Optional macro APB_TIMEOUT_EN aborts ACCESS phases that last TIMEOUT_CYCLES without PREADY.
module rv32i_apb_bridge #(
    parameter int         NUM_SLAVES     = 4,
    parameter logic [3:0] REGION         = 4'h1,
    parameter int         TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     d_req,
    input  logic                     d_wr_en,
    input  logic [31:0]              dAddr,
    input  logic [31:0]              dWdata,
    input  logic [2:0]               extend_controls,
    output logic [31:0]              dRdata,
    output logic                     d_ready,
    output logic                     d_err,
    output logic [31:0]              PADDR,
    output logic [31:0]              PWDATA,
    output logic                     PWRITE,
    output logic [3:0]               PSTRB,
    output logic [NUM_SLAVES-1:0]    PSEL,
    output logic                     PENABLE,
    input  logic [NUM_SLAVES*32-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY,
    input  logic [NUM_SLAVES-1:0]    PSLVERR
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETUP  = 2'd1;
    localparam logic [1:0] S_ACCESS = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    if (NUM_SLAVES < 1 || NUM_SLAVES > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
        $error("rv32i_apb_bridge: parameter out of range");
    end

    logic [1:0]            state;
    logic [3:0]            slot_q;
    logic [2:0]            funct3_q;
    logic [1:0]            lane_q;
    logic                  hit;
    logic                  bad_align;
    logic                  bad_f3;
    logic [3:0]            strb_n;
    logic [31:0]           wdata_n;
    logic [NUM_SLAVES-1:0] slot_dec;
    logic [31:0]           sel_rdata;
    logic                  sel_ready;
    logic                  sel_err;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_ext;
    logic                  timeout;

    always_comb begin
        hit    = (dAddr[31:28] == REGION) && ({28'd0, dAddr[15:12]} < NUM_SLAVES);
        bad_f3 = (extend_controls == 3'b011) || (extend_controls[2:1] == 2'b11);
        case (extend_controls[1:0])
            2'b01:   bad_align = dAddr[0];
            2'b10:   bad_align = |dAddr[1:0];
            default: bad_align = 1'b0;
        endcase
        // Narrow stores replicate the data on every lane; the strobes pick the live bytes.
        case (extend_controls[1:0])
            2'b00: begin
                strb_n  = 4'b0001 << dAddr[1:0];
                wdata_n = {4{dWdata[7:0]}};
            end
            2'b01: begin
                strb_n  = 4'b0011 << {dAddr[1], 1'b0};
                wdata_n = {2{dWdata[15:0]}};
            end
            default: begin
                strb_n  = 4'b1111;
                wdata_n = dWdata;
            end
        endcase
        if (!d_wr_en) begin
            strb_n = 4'b0000;
        end
    end

    always_comb begin
        slot_dec  = '0;
        sel_rdata = '0;
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slot_dec[i] = (slot_q == 4'(i));
            if (slot_dec[i]) begin
                sel_rdata = PRDATA[32*i +: 32];
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
            end
        end
    end

    always_comb begin
        rd_byte = sel_rdata[8*lane_q +: 8];
        rd_half = sel_rdata[16*lane_q[1] +: 16];
        case (funct3_q)
            3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_ext = {24'd0, rd_byte};
            3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_ext = {16'd0, rd_half};
            default: load_ext = sel_rdata;
        endcase
    end

`ifdef APB_TIMEOUT_EN
    logic [15:0] acc_cnt;

    always_ff @(posedge clk) begin
        if (reset || state != S_ACCESS) begin
            acc_cnt <= '0;
        end else begin
            acc_cnt <= acc_cnt + 16'd1;
        end
    end

    assign timeout = (acc_cnt == 16'(TIMEOUT_CYCLES - 1)) && !sel_ready;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            slot_q   <= '0;
            funct3_q <= '0;
            lane_q   <= '0;
            PADDR    <= '0;
            PWDATA   <= '0;
            PSTRB    <= '0;
            PWRITE   <= 1'b0;
            dRdata   <= '0;
            d_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (d_req) begin
                        if (!hit || bad_align || bad_f3) begin
                            state  <= S_RESP;
                            d_err  <= 1'b1;
                            dRdata <= '0;
                        end else begin
                            state    <= S_SETUP;
                            slot_q   <= dAddr[15:12];
                            funct3_q <= extend_controls;
                            lane_q   <= dAddr[1:0];
                            PADDR    <= {dAddr[31:2], 2'b00};
                            PWDATA   <= wdata_n;
                            PSTRB    <= strb_n;
                            PWRITE   <= d_wr_en;
                        end
                    end
                end
                S_SETUP: state <= S_ACCESS;
                S_ACCESS: begin
                    if (sel_ready) begin
                        state  <= S_RESP;
                        d_err  <= sel_err;
                        dRdata <= (sel_err || PWRITE) ? 32'd0 : load_ext;
                    end else if (timeout) begin
                        state  <= S_RESP;
                        d_err  <= 1'b1;
                        dRdata <= '0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign PSEL    = (state == S_SETUP || state == S_ACCESS) ? slot_dec : '0;
    assign PENABLE = (state == S_ACCESS);
    assign d_ready = (state == S_RESP);
endmodule

// File: tb/tb_rv32i_apb_bridge.sv
// tb/tb_rv32i_apb_bridge.sv - self-checking bench for rv32i_apb_bridge
module tb_rv32i_apb_bridge;
    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          d_req;
    logic          d_wr_en;
    logic [31:0]   dAddr;
    logic [31:0]   dWdata;
    logic [2:0]    extend_controls;
    logic [31:0]   dRdata;
    logic          d_ready;
    logic          d_err;
    logic [31:0]   PADDR;
    logic [31:0]   PWDATA;
    logic          PWRITE;
    logic [3:0]    PSTRB;
    logic [NS-1:0] PSEL;
    logic          PENABLE;
    logic [NS*32-1:0] PRDATA;
    logic [NS-1:0] PREADY;
    logic [NS-1:0] PSLVERR;

    always #5 clk = ~clk;

    rv32i_apb_bridge #(.NUM_SLAVES(NS), .REGION(4'h1), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .d_req(d_req), .d_wr_en(d_wr_en), .dAddr(dAddr),
        .dWdata(dWdata), .extend_controls(extend_controls), .dRdata(dRdata),
        .d_ready(d_ready), .d_err(d_err), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSTRB(PSTRB), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] prdata;
        int          waits;
        logic        slverr;
        logic [3:0]  e_psel;
        logic [31:0] e_paddr;
        logic [3:0]  e_strb;
        logic [31:0] e_pwdata;
        logic [31:0] e_rdata;
        logic        e_err;
        int          e_lat;
    } vec_t;

    vec_t vt[15];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [127:0] outs();
        return {dRdata, d_ready, d_err, PADDR, PWDATA, PWRITE, PSTRB, PSEL, PENABLE};
    endfunction

    // Reference: derived from access size, offset and sign rules with plain arithmetic.
    function automatic void model(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [2:0] f3, input logic [31:0] prdata, input int waits,
                                  input logic slverr, output logic [3:0] psel, output logic [31:0] paddr,
                                  output logic [3:0] strb, output logic [31:0] pwdata,
                                  output logic [31:0] rdata, output logic err, output int lat);
        longint la, size, off, mask, val, slot;
        bit ok;
        la   = longint'(addr);
        size = longint'(1) << int'(f3 % 4);
        slot = (la / 4096) % 16;
        ok   = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) && (la % size == 0) &&
               (la / 268435456 == 1) && (slot < NS);
        psel = 0; paddr = 0; strb = 0; pwdata = 0; rdata = 0;
        if (!ok) begin
            err = 1'b1;
            lat = 1;
            return;
        end
        off    = la % 4;
        mask   = (longint'(1) << (8 * size)) - 1;
        psel   = 4'(longint'(1) << slot);
        paddr  = 32'(la - off);
        strb   = wr ? 4'(((longint'(1) << size) - 1) << off) : 4'd0;
        pwdata = 32'((longint'(wdata) & mask) * (size == 1 ? 64'h01010101 : (size == 2 ? 64'h00010001 : 64'h1)));
        err    = slverr;
        lat    = 3 + waits;
        if (!wr && !slverr) begin
            val = (longint'(prdata) >> (8 * off)) & mask;
            if (f3 < 4 && val >= (mask + 1) / 2) val = val - (mask + 1);
            rdata = 32'(val);
        end
    endfunction

    // Drives one request and acts as the APB slave; o_lat=0 means no d_ready within bound.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [31:0] prdata, input int waits,
                        input logic slverr, input int bound,
                        output logic [3:0] o_psel, output logic [31:0] o_paddr, output logic [3:0] o_strb,
                        output logic [31:0] o_pwdata, output logic o_pwrite, output logic [31:0] o_rdata,
                        output logic o_err, output int o_lat, output logic o_proto);
        int acc;
        bit first;
        @(negedge clk);
        d_req = 1'b1; d_wr_en = wr; dAddr = addr; dWdata = wdata; extend_controls = f3;
        o_psel = 0; o_paddr = 0; o_strb = 0; o_pwdata = 0; o_pwrite = 0;
        o_rdata = 0; o_err = 0; o_lat = 0; o_proto = 1'b1;
        acc = 0; first = 1'b1;
        for (int c = 1; c <= bound; c++) begin
            @(negedge clk);
            if (d_ready) begin
                o_rdata = dRdata; o_err = d_err; o_lat = c;
                if (PSEL != 0 || PENABLE) o_proto = 1'b0;
                d_req = 1'b0;
                break;
            end
            PREADY  = NS'($urandom);
            PSLVERR = NS'($urandom);
            PRDATA  = {$urandom, $urandom, $urandom, $urandom};
            if (PSEL != 0) begin
                if (first) begin
                    o_psel = PSEL; o_paddr = PADDR; o_strb = PSTRB; o_pwdata = PWDATA; o_pwrite = PWRITE;
                    if (PENABLE) o_proto = 1'b0;
                    first = 1'b0;
                end else if ({PSEL, PADDR, PSTRB, PWDATA, PWRITE} != {o_psel, o_paddr, o_strb, o_pwdata, o_pwrite}
                             || !PENABLE) begin
                    o_proto = 1'b0;
                end
                if (PENABLE) begin
                    for (int i = 0; i < NS; i++) begin
                        if (PSEL[i]) begin
                            PREADY[i]         = (acc == waits);
                            PSLVERR[i]        = slverr;
                            PRDATA[32*i +: 32] = prdata;
                        end
                    end
                    acc++;
                end
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [2:0] f3, input logic [31:0] prdata,
                                 input int waits, input logic slverr, input logic [3:0] e_psel,
                                 input logic [31:0] e_paddr, input logic [3:0] e_strb,
                                 input logic [31:0] e_pwdata, input logic [31:0] e_rdata,
                                 input logic e_err, input int e_lat);
        logic [3:0] o_psel, o_strb;
        logic [31:0] o_paddr, o_pwdata, o_rdata;
        logic o_pwrite, o_err, o_proto;
        int o_lat;
        xfer(wr, addr, wdata, f3, prdata, waits, slverr, 40,
             o_psel, o_paddr, o_strb, o_pwdata, o_pwrite, o_rdata, o_err, o_lat, o_proto);
        chk({tag, "_lat"},   o_lat,   e_lat);
        chk({tag, "_err"},   o_err,   e_err);
        chk({tag, "_rdata"}, o_rdata, e_rdata);
        chk({tag, "_psel"},  o_psel,  e_psel);
        if (e_psel != 0) begin
            chk({tag, "_paddr"},  o_paddr,  e_paddr);
            chk({tag, "_pstrb"},  o_strb,   e_strb);
            chk({tag, "_pwrite"}, o_pwrite, wr);
            chk({tag, "_stable"}, o_proto,  1'b1);
            if (wr) chk({tag, "_pwdata"}, o_pwdata, e_pwdata);
        end
        if (o_lat == 0) begin
            reset = 1'b1; d_req = 1'b0;
            @(negedge clk);
            reset = 1'b0;
        end
    endtask

    initial begin
        logic [3:0] m_psel, m_strb, h_psel, h_strb;
        logic [31:0] m_paddr, m_pwdata, m_rdata, h_paddr, h_pwdata, h_rdata;
        logic m_err, h_pwrite, h_err, h_proto, seen;
        int m_lat, h_lat;

        vt[0]  = '{1'b1, 32'h1000_2008, 32'h1122_3344, 3'd2, 32'h0, 0, 1'b0, 4'b0100, 32'h1000_2008, 4'hF, 32'h1122_3344, 32'h0, 1'b0, 3};
        vt[1]  = '{1'b0, 32'h1000_1003, 32'h0, 3'd0, 32'h80FF_0000, 2, 1'b0, 4'b0010, 32'h1000_1000, 4'h0, 32'h0, 32'hFFFF_FF80, 1'b0, 5};
        vt[2]  = '{1'b0, 32'h1000_1003, 32'h0, 3'd4, 32'h80FF_0000, 2, 1'b0, 4'b0010, 32'h1000_1000, 4'h0, 32'h0, 32'h0000_0080, 1'b0, 5};
        vt[3]  = '{1'b1, 32'h1000_0002, 32'h1234_ABCD, 3'd1, 32'h0, 0, 1'b0, 4'b0001, 32'h1000_0000, 4'hC, 32'hABCD_ABCD, 32'h0, 1'b0, 3};
        vt[4]  = '{1'b0, 32'h1000_0002, 32'h0, 3'd5, 32'hABCD_0000, 0, 1'b0, 4'b0001, 32'h1000_0000, 4'h0, 32'h0, 32'h0000_ABCD, 1'b0, 3};
        vt[5]  = '{1'b0, 32'h1000_0002, 32'h0, 3'd1, 32'hABCD_0000, 0, 1'b0, 4'b0001, 32'h1000_0000, 4'h0, 32'h0, 32'hFFFF_ABCD, 1'b0, 3};
        vt[6]  = '{1'b0, 32'h2000_0000, 32'h0, 3'd2, 32'h0, 0, 1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1};
        vt[7]  = '{1'b0, 32'h1000_0001, 32'h0, 3'd2, 32'h0, 0, 1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1};
        vt[8]  = '{1'b0, 32'h1000_0004, 32'h0, 3'd2, 32'hDEAD_BEEF, 0, 1'b1, 4'b0001, 32'h1000_0004, 4'h0, 32'h0, 32'h0, 1'b1, 3};
        vt[9]  = '{1'b0, 32'h1000_0000, 32'h0, 3'd3, 32'h0, 0, 1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1};
        vt[10] = '{1'b0, 32'h1000_4000, 32'h0, 3'd2, 32'h0, 0, 1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1};
        vt[11] = '{1'b1, 32'h1000_3001, 32'h0000_00A5, 3'd0, 32'h0, 0, 1'b0, 4'b1000, 32'h1000_3000, 4'h2, 32'hA5A5_A5A5, 32'h0, 1'b0, 3};
        vt[12] = '{1'b0, 32'h1000_300C, 32'h0, 3'd2, 32'h0123_4567, 1, 1'b0, 4'b1000, 32'h1000_300C, 4'h0, 32'h0, 32'h0123_4567, 1'b0, 4};
        vt[13] = '{1'b0, 32'h1000_0003, 32'h0, 3'd5, 32'h0, 0, 1'b0, 4'b0000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1, 1};
        vt[14] = '{1'b1, 32'h1000_2000, 32'hCAFE_F00D, 3'd2, 32'h0, 3, 1'b1, 4'b0100, 32'h1000_2000, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b1, 6};

        reset = 1'b1; d_req = 1'b0; d_wr_en = 1'b0; dAddr = '0; dWdata = '0; extend_controls = '0;
        PRDATA = '0; PREADY = '0; PSLVERR = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs(), 128'd0);
        reset = 1'b0;

        for (int t = 0; t < 15; t++) begin
            run_and_check($sformatf("vec%0d", t), vt[t].wr, vt[t].addr, vt[t].wdata, vt[t].f3,
                          vt[t].prdata, vt[t].waits, vt[t].slverr, vt[t].e_psel, vt[t].e_paddr,
                          vt[t].e_strb, vt[t].e_pwdata, vt[t].e_rdata, vt[t].e_err, vt[t].e_lat);
            if (t == 0) begin
                @(negedge clk);
                chk("d_ready_one_cycle", d_ready, 1'b0);
            end
        end

        for (int k = 0; k < 60; k++) begin
            logic wr, se;
            logic [31:0] a, wd, pr;
            logic [2:0] f;
            int w;
            wr = 1'($urandom_range(0, 1));
            f  = 3'($urandom_range(0, 7));
            if ((f inside {3'd3, 3'd6, 3'd7}) && $urandom_range(0, 2) != 0) f = 3'd2;
            a = $urandom;
            if ($urandom_range(0, 5) != 0) a[31:28] = 4'h1;
            a[15:12] = 4'($urandom_range(0, 5));
            if ($urandom_range(0, 3) != 0) begin
                if (f[1:0] == 2'b10) a[1:0] = 2'b00;
                else if (f[1:0] == 2'b01) a[0] = 1'b0;
            end
            wd = $urandom; pr = $urandom;
            w  = $urandom_range(0, 3);
            se = ($urandom_range(0, 7) == 0);
            model(wr, a, wd, f, pr, w, se, m_psel, m_paddr, m_strb, m_pwdata, m_rdata, m_err, m_lat);
            run_and_check($sformatf("rnd%0d", k), wr, a, wd, f, pr, w, se,
                          m_psel, m_paddr, m_strb, m_pwdata, m_rdata, m_err, m_lat);
        end

        // Reset while the slave is stalling in ACCESS.
        @(negedge clk);
        d_req = 1'b1; d_wr_en = 1'b0; dAddr = 32'h1000_0000; extend_controls = 3'd2; PREADY = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            PREADY = '0;
            if (PENABLE) break;
        end
        chk("mid_reach_access", PENABLE, 1'b1);
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", outs(), 128'd0);
        reset = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | d_ready | (|PSEL);
        end
        chk("mid_reset_no_ready", seen, 1'b0);

        // Slave never ready.
        xfer(1'b0, 32'h1000_0000, 32'h0, 3'd2, 32'h5555_5555, 1000000, 1'b0, 100,
             h_psel, h_paddr, h_strb, h_pwdata, h_pwrite, h_rdata, h_err, h_lat, h_proto);
`ifdef APB_TIMEOUT_EN
        chk("timeout_lat",   h_lat,   10);
        chk("timeout_err",   h_err,   1'b1);
        chk("timeout_rdata", h_rdata, 32'd0);
`else
        chk("hang_no_ready",    h_lat, 0);
        chk("hang_still_access", {PSEL, PENABLE}, {4'b0001, 1'b1});
        chk("hang_stable",      h_proto, 1'b1);
`endif
        reset = 1'b1; d_req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("final_idle", outs(), 128'd0 | {dRdata, 1'b0, d_err, PADDR, PWDATA, PWRITE, PSTRB, 4'b0000, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
